// File: rtl/ecpmultidly_if.sv
// Command, status and DELAYF control lines of the multi-group delay controller.
// The master drives commands and CFLAG feedback; the slave (the controller) drives MOVE/DIRECTION and status.
interface ecpmultidly_if #(
  parameter int NG    = 2,
  parameter int NP    = 4,
  parameter int NBITS = 7
);
  logic [NG*NBITS-1:0] i_commanded_delay;
  logic [NG-1:0]       i_resync;
  logic [NG*NP-1:0]    i_dly_cflag;
  logic [NG-1:0]       o_dly_move;
  logic [NG-1:0]       o_dly_direction;
  logic [NG*NBITS-1:0] o_current_delay;
  logic [NG-1:0]       o_syncd;
  logic [NG-1:0]       o_settled;
  logic [NG-1:0]       o_error;

  modport master (
    output i_commanded_delay, i_resync, i_dly_cflag,
    input  o_dly_move, o_dly_direction, o_current_delay, o_syncd, o_settled, o_error
  );

  modport slave (
    input  i_commanded_delay, i_resync, i_dly_cflag,
    output o_dly_move, o_dly_direction, o_current_delay, o_syncd, o_settled, o_error
  );
endinterface

// File: rtl/ecpmultidly.sv
// Controller for NG independent groups of ECP5 DELAYF elements: zeroes each group
// against CFLAG, then steps MOVE/DIRECTION one tap per strobe pair toward the commanded tap.
module ecpmultidly #(
  parameter int NG     = 2,
  parameter int NP     = 4,
  parameter int NBITS  = 7,
  parameter int MAXTAP = 127,
  parameter int CKDIV  = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  ecpmultidly_if.slave bus
);

  typedef enum logic [1:0] {ZERO, IDLE, STEP} state_t;

  localparam logic [NBITS-1:0] MAX_TAP = NBITS'(MAXTAP);

  logic [CKDIV-1:0] stb_cnt;
  logic             ck_stb;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset branch first.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) stb_cnt <= '0;
    else         stb_cnt <= stb_cnt + 1'b1;
  end

  assign ck_stb = &stb_cnt;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    state_t           state, state_nx;
    logic             move, move_nx;
    logic             dir, dir_nx;        // 1 = DOWN
    logic             maxed, maxed_nx;
    logic             syncd, syncd_nx;
    logic             err, err_nx;
    logic             pend, pend_nx;
    logic [NBITS-1:0] cur, cur_nx;
    logic [NBITS-1:0] cmd, target;
    logic [NP-1:0]    cflag;
    logic             all_hi, all_lo;

    assign cmd    = bus.i_commanded_delay[g*NBITS +: NBITS];
    assign target = (cmd > MAX_TAP) ? MAX_TAP : cmd;
    assign cflag  = bus.i_dly_cflag[g*NP +: NP];
    assign all_hi = &cflag;
    assign all_lo = ~|cflag;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        state <= ZERO;
        move  <= 1'b0;
        dir   <= 1'b1;
        maxed <= 1'b0;
        syncd <= 1'b0;
        err   <= 1'b0;
        pend  <= 1'b0;
        cur   <= '0;
      end else begin
        state <= state_nx;
        move  <= move_nx;
        dir   <= dir_nx;
        maxed <= maxed_nx;
        syncd <= syncd_nx;
        err   <= err_nx;
        pend  <= pend_nx;
        cur   <= cur_nx;
      end
    end

    // NOTE: every combinational output is given its hold value first so no path infers a latch.
    always_comb begin
      state_nx = state;
      move_nx  = move;
      dir_nx   = dir;
      maxed_nx = maxed;
      syncd_nx = syncd;
      err_nx   = err;
      pend_nx  = pend | bus.i_resync[g];
      cur_nx   = cur;

      case (state)
        ZERO: begin
          // Walk DOWN until every lane reports it hit tap 0; resync requests are moot here.
          dir_nx  = 1'b1;
          pend_nx = 1'b0;
          if (ck_stb) begin
            if (!move) begin
              move_nx = 1'b1;
            end else begin
              move_nx = 1'b0;
              if (all_hi) begin
                syncd_nx = 1'b1;
                cur_nx   = '0;
                maxed_nx = 1'b0;
                state_nx = IDLE;
              end
            end
          end
        end

        IDLE: begin
          // Direction is settled off-strobe so it is stable a full clock before MOVE rises.
          if (!ck_stb && !move) dir_nx = (cur > target);
          if (ck_stb && !move) begin
            if (pend) begin
              syncd_nx = 1'b0;
              pend_nx  = 1'b0;
              state_nx = ZERO;
            end else if ((cur != target) && !(!dir && maxed)) begin
              move_nx  = 1'b1;
              state_nx = STEP;
            end
          end
        end

        STEP: begin
          if (ck_stb) begin
            move_nx  = 1'b0;
            state_nx = IDLE;
            if (!all_hi && !all_lo) begin
              err_nx   = 1'b1;
              syncd_nx = 1'b0;
              state_nx = ZERO;
            end else if (dir) begin
              cur_nx   = (cur == '0) ? '0 : cur - 1'b1;
              maxed_nx = 1'b0;
            end else if (all_lo) begin
              cur_nx = cur + 1'b1;
            end else begin
              maxed_nx = 1'b1;
            end
          end
        end

        default: state_nx = ZERO;
      endcase
    end

    assign bus.o_dly_move[g]                        = move;
    assign bus.o_dly_direction[g]                   = dir;
    assign bus.o_current_delay[g*NBITS +: NBITS]    = syncd ? cur : '0;
    assign bus.o_syncd[g]                           = syncd;
    assign bus.o_error[g]                           = err;
    assign bus.o_settled[g] = syncd && !move &&
                              ((cur == target) || (maxed && (target > cur)));
  end

endmodule

// File: tb/tb_ecpmultidly.sv
// Directed and randomized bench for ecpmultidly with a behavioural DELAYF/CFLAG lane model.
module tb_ecpmultidly;
  localparam int NG = 2, NP = 4, NBITS = 7, MAXTAP = 60, CKDIV = 2;
  localparam int STB = 1 << CKDIV;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  ecpmultidly_if #(.NG(NG), .NP(NP), .NBITS(NBITS)) bus ();

  ecpmultidly #(.NG(NG), .NP(NP), .NBITS(NBITS), .MAXTAP(MAXTAP), .CKDIV(CKDIV)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Lane model: each MOVE rise moves the tap one step; a move past the end of range sets CFLAG instead.
  int tap [NG][NP] = '{'{3, 3, 3, 3}, '{3, 3, 3, 3}};
  bit cf [NG][NP];
  bit force_hi [NG][NP];
  int lane_max [NG] = '{127, 127};

  int up_cnt [NG], dn_cnt [NG];
  int hi_len [NG], lo_len [NG];
  int width_bad = 0, gap_bad = 0, dir_bad = 0;
  bit pm [NG], pdir [NG];

  always_comb begin
    for (int g = 0; g < NG; g++)
      for (int p = 0; p < NP; p++)
        bus.i_dly_cflag[g*NP + p] = cf[g][p] | force_hi[g][p];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      if (rst) begin
        hi_len[g] = 0;
        lo_len[g] = 100;
      end else begin
        if (bus.o_dly_move[g] && !pm[g]) begin
          if (lo_len[g] < STB) gap_bad++;
          for (int p = 0; p < NP; p++) begin
            if (bus.o_dly_direction[g]) begin
              if (tap[g][p] == 0) cf[g][p] = 1'b1;
              else begin tap[g][p]--; cf[g][p] = 1'b0; end
            end else begin
              if (tap[g][p] >= lane_max[g]) cf[g][p] = 1'b1;
              else begin tap[g][p]++; cf[g][p] = 1'b0; end
            end
          end
          if (bus.o_dly_direction[g]) dn_cnt[g]++;
          else                        up_cnt[g]++;
          hi_len[g] = 1;
        end else if (bus.o_dly_move[g]) begin
          hi_len[g]++;
        end else if (pm[g]) begin
          if (hi_len[g] != STB) width_bad++;
          lo_len[g] = 1;
        end else begin
          lo_len[g]++;
        end
        if ((bus.o_dly_move[g] || pm[g]) && (bus.o_dly_direction[g] != pdir[g])) dir_bad++;
      end
      pm[g]   = bus.o_dly_move[g];
      pdir[g] = bus.o_dly_direction[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampt(input int c);
    return (c > MAXTAP) ? MAXTAP : c;
  endfunction

  function automatic int cur(input int g);
    return int'(bus.o_current_delay[g*NBITS +: NBITS]);
  endfunction

  // Avoid changing the command in the strobe cycle itself, so direction is re-evaluated first.
  task automatic set_cmd(input int c0, input int c1);
    @(negedge clk);
    while (cyc % STB == STB - 1) @(negedge clk);
    bus.i_commanded_delay = {NBITS'(c1), NBITS'(c0)};
  endtask

  // sel: 0 = MOVE[g], 1 = SYNCD[g], 2 = all groups settled
  task automatic wait_for(input int sel, input int g, input bit level, input int bound, output bit ok);
    bit v;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      case (sel)
        0:       v = bus.o_dly_move[g];
        1:       v = bus.o_syncd[g];
        default: v = &bus.o_settled;
      endcase
      if (v == level) begin ok = 1'b1; break; end
    end
  endtask

  int up0 [NG], dn0 [NG];
  int prev_t [NG];
  int c [NG];
  int wb0, db0;
  bit ok;

  task automatic snap();
    for (int g = 0; g < NG; g++) begin up0[g] = up_cnt[g]; dn0[g] = dn_cnt[g]; end
    wb0 = width_bad + gap_bad;
    db0 = dir_bad;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_commanded_delay = '0;
    bus.i_resync = '0;
    repeat (2) @(negedge clk);
    check("rst_move", bus.o_dly_move, 2'b00);
    check("rst_dir", bus.o_dly_direction, 2'b11);
    check("rst_cur", bus.o_current_delay, '0);
    check("rst_syncd", bus.o_syncd, 2'b00);
    check("rst_settled", bus.o_settled, 2'b00);
    check("rst_error", bus.o_error, 2'b00);

    // Initial zeroing from tap 3: four DOWN pulses, synced by clock 33.
    snap();
    rst = 1'b0;
    repeat (33) @(posedge clk);
    @(negedge clk);
    check("sync_syncd", bus.o_syncd, 2'b11);
    check("sync_cur", bus.o_current_delay, '0);
    check("sync_dn0", dn_cnt[0] - dn0[0], 4);
    check("sync_dn1", dn_cnt[1] - dn0[1], 4);
    check("sync_up", up_cnt[0] + up_cnt[1], 0);
    check("sync_width", width_bad + gap_bad, 0);

    // Group 0 to 5, group 1 stays at 0.
    snap();
    set_cmd(5, 0);
    wait_for(2, 0, 1'b1, 48, ok);
    check("up5_settle_in_time", ok, 1'b1);
    check("up5_cur0", cur(0), 5);
    check("up5_settled", bus.o_settled, 2'b11);
    check("up5_up0", up_cnt[0] - up0[0], 5);
    check("up5_g1_moves", (up_cnt[1] - up0[1]) + (dn_cnt[1] - dn0[1]), 0);

    // Group 0 down to 2, direction held steady around each pulse.
    snap();
    set_cmd(2, 0);
    wait_for(2, 0, 1'b1, 60, ok);
    check("dn2_settle", ok, 1'b1);
    check("dn2_cur0", cur(0), 2);
    check("dn2_dn0", dn_cnt[0] - dn0[0], 3);
    check("dn2_dir_stable", dir_bad - db0, 0);

    // Lanes top out at tap 4 while commanded 9.
    set_cmd(0, 0);
    wait_for(2, 0, 1'b1, 60, ok);
    check("max_prezero", cur(0), 0);
    lane_max[0] = 4;
    snap();
    set_cmd(9, 0);
    wait_for(2, 0, 1'b1, 80, ok);
    check("max_settle", ok, 1'b1);
    check("max_cur0", cur(0), 4);
    check("max_up0", up_cnt[0] - up0[0], 5);
    check("max_settled0", bus.o_settled[0], 1'b1);
    repeat (40) @(negedge clk);
    check("max_no_more_moves", (up_cnt[0] - up0[0]) + (dn_cnt[0] - dn0[0]), 5);
    snap();
    set_cmd(1, 0);
    wait_for(2, 0, 1'b1, 60, ok);
    check("max_back_cur0", cur(0), 1);
    check("max_back_dn0", dn_cnt[0] - dn0[0], 3);
    lane_max[0] = 127;

    // Randomized commands, including values above MAXTAP that must clamp.
    prev_t[0] = 1;
    prev_t[1] = 0;
    for (int r = 0; r < 6; r++) begin
      snap();
      c[0] = $urandom_range(0, 127);
      c[1] = $urandom_range(0, 127);
      set_cmd(c[0], c[1]);
      wait_for(2, 0, 1'b1, 600, ok);
      check($sformatf("rnd%0d_settle", r), ok, 1'b1);
      for (int g = 0; g < NG; g++) begin
        int t;
        t = clampt(c[g]);
        check($sformatf("rnd%0d_cur%0d", r, g), cur(g), t);
        check($sformatf("rnd%0d_up%0d", r, g), up_cnt[g] - up0[g], (t > prev_t[g]) ? t - prev_t[g] : 0);
        check($sformatf("rnd%0d_dn%0d", r, g), dn_cnt[g] - dn0[g], (t < prev_t[g]) ? prev_t[g] - t : 0);
        prev_t[g] = t;
      end
      check($sformatf("rnd%0d_shape", r), (width_bad + gap_bad) - wb0 + dir_bad - db0, 0);
    end

    // Resync group 1 in the middle of an UP step.
    set_cmd(0, 0);
    wait_for(2, 0, 1'b1, 600, ok);
    check("rs_prezero", bus.o_current_delay, '0);
    snap();
    set_cmd(0, 3);
    wait_for(0, 1, 1'b1, 20, ok);
    check("rs_move_start", ok, 1'b1);
    bus.i_resync = 2'b10;
    @(negedge clk);
    bus.i_resync = 2'b00;
    wait_for(0, 1, 1'b0, 10, ok);
    check("rs_step_done", ok, 1'b1);
    check("rs_cur1_after_step", cur(1), 1);
    wait_for(1, 1, 1'b0, 20, ok);
    check("rs_syncd_fell", ok, 1'b1);
    check("rs_cur1_unsynced", cur(1), 0);
    wait_for(1, 1, 1'b1, 40, ok);
    check("rs_resynced", ok, 1'b1);
    wait_for(2, 0, 1'b1, 60, ok);
    check("rs_cur1_final", cur(1), 3);
    check("rs_g0_quiet", (up_cnt[0] - up0[0]) + (dn_cnt[0] - dn0[0]), 0);
    check("rs_g0_syncd", bus.o_syncd[0], 1'b1);
    check("rs_no_error", bus.o_error, 2'b00);

    // One lane stuck high during an UP step on group 0.
    set_cmd(6, 3);
    wait_for(0, 0, 1'b1, 20, ok);
    check("err_move_start", ok, 1'b1);
    force_hi[0][2] = 1'b1;
    wait_for(0, 0, 1'b0, 10, ok);
    check("err_error", bus.o_error, 2'b01);
    check("err_syncd0", bus.o_syncd[0], 1'b0);
    check("err_cur0", cur(0), 0);
    force_hi[0][2] = 1'b0;
    wait_for(0, 0, 1'b1, 20, ok);
    check("err_rezero_move", ok, 1'b1);
    check("err_rezero_down", bus.o_dly_direction[0], 1'b1);
    wait_for(1, 0, 1'b1, 40, ok);
    check("err_resynced", ok, 1'b1);
    check("err_sticky", bus.o_error, 2'b01);

    // Asynchronous reset mid-move.
    wait_for(0, 0, 1'b1, 20, ok);
    check("arst_move_start", ok, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_move", bus.o_dly_move, 2'b00);
    check("arst_dir", bus.o_dly_direction, 2'b11);
    check("arst_cur", bus.o_current_delay, '0);
    check("arst_syncd", bus.o_syncd, 2'b00);
    check("arst_settled", bus.o_settled, 2'b00);
    check("arst_error", bus.o_error, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
